// File: rtl/udp2eth.sv
// ----------------------------------------------------------------------------
// udp2eth -- receive-side UDP deframer.
//
// Takes 512-bit Ethernet frames from the RX MAC (byte 0 in TDATA[7:0]).
// Beat 0 carries the 42-byte Eth/IPv4/UDP header, which is validated and
// stripped. The UDP payload is realigned to byte 0 and sent on AXIS_TX.
// Its byte count (UDP length - 8) is announced on AXIS_LEN before the
// payload starts.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   AXIS_RX_*  (in)             Ethernet frame stream from the MAC
//   AXIS_TX_*  (out)            realigned UDP payload stream
//   AXIS_LEN_* (out)            payload length, one word per accepted frame
//   drop_count                  frames rejected by header checks (wraps)
//   trunc_count                 frames shorter than their UDP length (wraps)
//
// Parameters
//   LOCAL_IP  required IPv4 destination address
//   DST_PORT  required UDP destination port
//   BCAST_OK  also accept any destination IP whose low byte is 8'hFF
//
// Build option
//   IP_CSUM_CHECK_EN  when defined, the IPv4 header checksum (bytes 14..33)
//                     must fold to 16'hFFFF or the frame is dropped.
//
// Handshake semantics (all three streams): a transfer happens on a rising
// clk edge where TVALID and TREADY are both 1. Once TVALID is raised,
// TVALID and its payload signals stay stable until that transfer.
// ----------------------------------------------------------------------------
module udp2eth #(
    parameter logic [31:0] LOCAL_IP = 32'h0A010102,
    parameter logic [15:0] DST_PORT = 16'd32000,
    parameter bit          BCAST_OK = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [511:0] AXIS_RX_TDATA,
    input  logic [63:0]  AXIS_RX_TKEEP,
    input  logic         AXIS_RX_TVALID,
    input  logic         AXIS_RX_TLAST,
    output logic         AXIS_RX_TREADY,
    output logic [511:0] AXIS_TX_TDATA,
    output logic [63:0]  AXIS_TX_TKEEP,
    output logic         AXIS_TX_TVALID,
    output logic         AXIS_TX_TLAST,
    input  logic         AXIS_TX_TREADY,
    output logic [15:0]  AXIS_LEN_TDATA,
    output logic         AXIS_LEN_TVALID,
    input  logic         AXIS_LEN_TREADY,
    output logic [31:0]  drop_count,
    output logic [31:0]  trunc_count
);

    typedef enum logic [1:0] {S_HDR, S_DATA, S_FLUSH, S_DROP} state_e;

    state_e         state_q, state_d;
    logic [175:0]   res_q, res_d;          // 22 carried-over payload bytes
    logic [4:0]     res_cnt_q, res_cnt_d;  // how many of them are valid
    logic [15:0]    rem_q, rem_d;          // payload bytes still to emit
    logic [31:0]    drop_q, drop_d;
    logic [31:0]    trunc_q, trunc_d;

    function automatic logic [7:0] byte_of(input logic [511:0] d, input int n);
        return d[8*n +: 8];
    endfunction

    function automatic logic [63:0] ones(input logic [6:0] n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (7'(i) < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // ---------------- header field decode (beat 0) ----------------
    logic [15:0] eth_type;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic [15:0] pay_len;
    logic        ip_ok;
    logic        csum_ok;
    logic        hdr_ok;

    assign eth_type = {byte_of(AXIS_RX_TDATA, 12), byte_of(AXIS_RX_TDATA, 13)};
    assign dst_ip   = {byte_of(AXIS_RX_TDATA, 30), byte_of(AXIS_RX_TDATA, 31),
                       byte_of(AXIS_RX_TDATA, 32), byte_of(AXIS_RX_TDATA, 33)};
    assign dst_port = {byte_of(AXIS_RX_TDATA, 36), byte_of(AXIS_RX_TDATA, 37)};
    assign udp_len  = {byte_of(AXIS_RX_TDATA, 38), byte_of(AXIS_RX_TDATA, 39)};
    assign pay_len  = udp_len - 16'd8;
    assign ip_ok    = (dst_ip == LOCAL_IP) || (BCAST_OK && (dst_ip[7:0] == 8'hFF));

`ifdef IP_CSUM_CHECK_EN
    // Ones-complement sum of the ten IPv4 header words, folded twice
    // (ten 16-bit words never exceed 20 bits before folding).
    logic [19:0] csum_acc;
    logic [16:0] csum_f1;
    logic [15:0] csum_sum;
    always_comb begin
        csum_acc = '0;
        for (int k = 0; k < 10; k++) begin
            csum_acc = csum_acc + {4'd0, byte_of(AXIS_RX_TDATA, 14 + 2*k),
                                         byte_of(AXIS_RX_TDATA, 15 + 2*k)};
        end
        csum_f1  = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
        csum_sum = csum_f1[15:0] + {15'd0, csum_f1[16]};
    end
    assign csum_ok = (csum_sum == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    assign hdr_ok = (eth_type == 16'h0800)
                 && (byte_of(AXIS_RX_TDATA, 14) == 8'h45)
                 && (byte_of(AXIS_RX_TDATA, 23) == 8'h11)
                 && ip_ok
                 && (dst_port == DST_PORT)
                 && (udp_len >= 16'd9)
                 && (&AXIS_RX_TKEEP[41:0])
                 && csum_ok;

    // ---------------- beat byte accounting ----------------
    logic [6:0] rx_cnt;      // valid bytes in the RX beat (TKEEP is contiguous)
    logic [4:0] rx_hi_cnt;   // valid bytes among RX bytes 42..63
    logic [6:0] avail;       // bytes an S_DATA output beat can carry
    logic       enough;      // this S_DATA beat completes the payload
    logic [6:0] emit;
    logic       fl_enough;   // residual alone completes the payload
    logic [6:0] fl_emit;

    always_comb begin
        rx_cnt = '0;
        for (int i = 0; i < 64; i++) begin
            rx_cnt = rx_cnt + {6'd0, AXIS_RX_TKEEP[i]};
        end
    end

    assign rx_hi_cnt = (rx_cnt > 7'd42) ? 5'(rx_cnt - 7'd42) : 5'd0;
    assign avail     = {2'b00, res_cnt_q} + ((rx_cnt > 7'd42) ? 7'd42 : rx_cnt);
    assign enough    = (rem_q <= {9'd0, avail});
    assign emit      = enough ? rem_q[6:0] : avail;
    assign fl_enough = (rem_q <= {11'd0, res_cnt_q});
    assign fl_emit   = fl_enough ? rem_q[6:0] : {2'b00, res_cnt_q};

    // ---------------- FSM: next state and outputs ----------------
    logic         rx_ready;
    logic         tx_valid;
    logic [511:0] tx_data;
    logic [63:0]  tx_keep;
    logic         tx_last;
    logic         len_valid;

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        rem_d     = rem_q;
        drop_d    = drop_q;
        trunc_d   = trunc_q;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_keep   = '0;
        tx_last   = 1'b0;
        len_valid = 1'b0;

        case (state_q)
            S_HDR: begin
                if (AXIS_RX_TVALID) begin
                    if (hdr_ok) begin
                        // Beat 0 is held (and thus LEN stays valid) until the
                        // length word is taken; both transfer together.
                        len_valid = 1'b1;
                        rx_ready  = AXIS_LEN_TREADY;
                        if (AXIS_LEN_TREADY) begin
                            res_d     = AXIS_RX_TDATA[511:336];
                            res_cnt_d = rx_hi_cnt;
                            rem_d     = pay_len;
                            state_d   = AXIS_RX_TLAST ? S_FLUSH : S_DATA;
                        end
                    end else begin
                        rx_ready = 1'b1;
                        drop_d   = drop_q + 32'd1;
                        state_d  = AXIS_RX_TLAST ? S_HDR : S_DROP;
                    end
                end
            end

            S_DATA: begin
                // Output beat = residual in bytes 0..21, RX bytes 0..41 above.
                tx_valid = AXIS_RX_TVALID;
                rx_ready = AXIS_TX_TREADY;
                tx_data  = {AXIS_RX_TDATA[335:0], res_q};
                tx_keep  = ones(emit);
                // Ends the payload, or ends a short frame with nothing left over.
                tx_last  = enough || (AXIS_RX_TLAST && (rx_cnt <= 7'd42));
                if (AXIS_RX_TVALID && AXIS_TX_TREADY) begin
                    res_d     = AXIS_RX_TDATA[511:336];
                    res_cnt_d = rx_hi_cnt;
                    rem_d     = rem_q - {9'd0, emit};
                    if (enough) begin
                        state_d = AXIS_RX_TLAST ? S_HDR : S_DROP;
                    end else if (AXIS_RX_TLAST) begin
                        if (rx_cnt > 7'd42) begin
                            state_d = S_FLUSH;
                        end else begin
                            trunc_d = trunc_q + 32'd1;
                            state_d = S_HDR;
                        end
                    end
                end
            end

            S_FLUSH: begin
                tx_valid = 1'b1;
                tx_data  = {336'd0, res_q};
                tx_keep  = ones(fl_emit);
                tx_last  = 1'b1;
                if (AXIS_TX_TREADY) begin
                    if (!fl_enough) trunc_d = trunc_q + 32'd1;
                    state_d = S_HDR;
                end
            end

            S_DROP: begin
                rx_ready = 1'b1;
                if (AXIS_RX_TVALID && AXIS_RX_TLAST) state_d = S_HDR;
            end

            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_HDR;
            res_q     <= '0;
            res_cnt_q <= '0;
            rem_q     <= '0;
            drop_q    <= '0;
            trunc_q   <= '0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
            rem_q     <= rem_d;
            drop_q    <= drop_d;
            trunc_q   <= trunc_d;
        end
    end

    // Valids and RX ready are forced low while reset is asserted, since the
    // FSM decodes them combinationally from the live inputs.
    assign AXIS_RX_TREADY  = resetn & rx_ready;
    assign AXIS_TX_TVALID  = resetn & tx_valid;
    assign AXIS_TX_TDATA   = tx_data;
    assign AXIS_TX_TKEEP   = tx_keep;
    assign AXIS_TX_TLAST   = tx_last;
    assign AXIS_LEN_TVALID = resetn & len_valid;
    assign AXIS_LEN_TDATA  = pay_len;
    assign drop_count      = drop_q;
    assign trunc_count     = trunc_q;

endmodule
